// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: VGA scan-out reads take the single-port RAM during
// the active area; a pixel writer is served in the remaining cycles. Scan-out
// pixels come back registered, two cycles after the hcount/vcount sample.
module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              frame_start
);

    // Pixel count held one bit wider than the address so it is representable
    // even when the framebuffer exactly fills the address space.
    localparam logic [ADDR_W:0]   PIX_TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W:0]   PIX_LAST  = PIX_TOTAL - (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
    localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);

    // Writer FSM: a grant is followed by two dead cycles so a request that is
    // still high with stale data is never written twice.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAck  = 2'd1;
    localparam logic [1:0] StTurn = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              frame_start_q, frame_start_d;
    logic              rd_s1_q, rd_s1_d;
    logic              rd_s2_q, rd_s2_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;

    logic              read_slot;
    logic              frame_origin;
    logic              wr_in_range;
    logic [ADDR_W-1:0] rd_addr;

    // Decode the current timing sample and the writer's address range.
    always_comb begin
        read_slot    = (hcount < H_LIM) && (vcount < V_LIM);
        frame_origin = (hcount == 11'd0) && (vcount == 10'd0);
        wr_in_range  = {1'b0, wr_addr} < PIX_TOTAL;
        // The pointer reloads at the frame origin so address 0 is read that cycle.
        rd_addr      = frame_origin ? '0 : rd_ptr_q;
    end

    // Next-state for the writer FSM, the RAM port and the pixel pipeline.
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        wr_ack_d      = 1'b0;
        wr_err_d      = 1'b0;
        frame_start_d = frame_origin;

        // The FSM sequence is independent of read slots; only the grant is blocked.
        unique case (state_q)
            StIdle:  if (!read_slot && wr_req) state_d = StAck;
            StAck:   state_d = StTurn;
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (read_slot) begin
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr;
            rd_ptr_d   = ({1'b0, rd_addr} == PIX_LAST) ? '0 : rd_addr + ADDR_ONE;
        end else if (state_q == StIdle && wr_req) begin
            wr_ack_d = 1'b1;
            if (wr_in_range) begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
            end else begin
                // Out-of-range writes are consumed but never reach the RAM.
                wr_err_d = 1'b1;
            end
        end

        // Read issued at edge k, RAM data valid after k+1, captured at k+2.
        rd_s1_d     = read_slot;
        rd_s2_d     = rd_s1_q;
        pix_valid_d = rd_s2_q;
        pix_data_d  = rd_s2_q ? mem_rdata : pix_data_q;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            rd_ptr_q      <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            wr_ack_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            frame_start_q <= 1'b0;
            rd_s1_q       <= 1'b0;
            rd_s2_q       <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            wr_ack_q      <= wr_ack_d;
            wr_err_q      <= wr_err_d;
            frame_start_q <= frame_start_d;
            rd_s1_q       <= rd_s1_d;
            rd_s2_q       <= rd_s2_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
        end
    end

    assign wr_ack      = wr_ack_q;
    assign wr_err      = wr_err_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;

endmodule
